// File: rtl/instruction_loader.sv
// Byte-stream loader that assembles little-endian words and writes them to instruction memory.
// Define CHECKSUM_EN to expect a trailing 32-bit XOR checksum word after the instructions.
module instruction_loader #(
  parameter int ADDR_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH:0]   word_count
);

  localparam logic [31:0] MAX_WORDS = 32'(1 << ADDR_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_LOAD,
`ifdef CHECKSUM_EN
    S_CHECK,
`endif
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            byte_idx_q, byte_idx_d;
  logic [23:0]           word_buf_q, word_buf_d;
  logic [ADDR_WIDTH:0]   n_q, n_d;
  logic [ADDR_WIDTH:0]   word_count_q, word_count_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic                  err_q, err_d;
`ifdef CHECKSUM_EN
  logic [31:0]           csum_q, csum_d;
`endif

  logic                  accept;
  logic                  word_done;
  logic [31:0]           full_word;
  logic [ADDR_WIDTH:0]   count_inc;

  assign in_ready   = busy;
  assign done       = (state_q == S_DONE);
  assign err        = err_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign word_count = word_count_q;

  always_comb begin
    busy = (state_q == S_HEADER) || (state_q == S_LOAD);
`ifdef CHECKSUM_EN
    busy = busy || (state_q == S_CHECK);
`endif
  end

  assign accept    = in_valid & in_ready;
  assign word_done = accept && (byte_idx_q == 2'd3);
  assign full_word = {in_data, word_buf_q};
  assign count_inc = word_count_q + (ADDR_WIDTH+1)'(1);

  always_comb begin
    state_d      = state_q;
    byte_idx_d   = byte_idx_q;
    word_buf_d   = word_buf_q;
    n_d          = n_q;
    word_count_d = word_count_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    err_d        = err_q;
`ifdef CHECKSUM_EN
    csum_d       = csum_q;
`endif

    if (accept) begin
      byte_idx_d = byte_idx_q + 2'd1;
      case (byte_idx_q)
        2'd0:    word_buf_d[7:0]   = in_data;
        2'd1:    word_buf_d[15:8]  = in_data;
        2'd2:    word_buf_d[23:16] = in_data;
        default: word_buf_d        = word_buf_q;
      endcase
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d      = S_HEADER;
          byte_idx_d   = 2'd0;
          word_count_d = '0;
          err_d        = 1'b0;
`ifdef CHECKSUM_EN
          csum_d       = '0;
`endif
        end
      end
      S_HEADER: begin
        if (word_done) begin
          if (full_word == 32'd0) begin
            state_d = S_DONE;
            err_d   = 1'b0;
          end else if (full_word > MAX_WORDS) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end else begin
            n_d     = full_word[ADDR_WIDTH:0];
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        // The write is registered, so it lands exactly one cycle after the completing byte.
        if (word_done) begin
          mem_we_d     = 1'b1;
          mem_addr_d   = word_count_q[ADDR_WIDTH-1:0];
          mem_wdata_d  = full_word;
          word_count_d = count_inc;
`ifdef CHECKSUM_EN
          csum_d       = csum_q ^ full_word;
          if (count_inc == n_q) state_d = S_CHECK;
`else
          if (count_inc == n_q) state_d = S_DONE;
`endif
        end
      end
`ifdef CHECKSUM_EN
      S_CHECK: begin
        if (word_done) begin
          err_d   = (full_word != csum_q);
          state_d = S_DONE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      byte_idx_q   <= 2'd0;
      word_buf_q   <= '0;
      n_q          <= '0;
      word_count_q <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      err_q        <= 1'b0;
`ifdef CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      byte_idx_q   <= byte_idx_d;
      word_buf_q   <= word_buf_d;
      n_q          <= n_d;
      word_count_q <= word_count_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      err_q        <= err_d;
`ifdef CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

endmodule
